// File: rtl/pp_pipeline_accel_blk_geom_pkg.sv
// Shared types and width helpers for the block-geometry calculator.
package pp_pipeline_accel_blk_geom_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int calc_nppc_w(input int max_nppc);
    return $clog2(max_nppc + 1);
  endfunction

  function automatic int calc_ww(input int max_nppc, input int pxl_w);
    return $clog2(max_nppc + 1) + $clog2(pxl_w + 1);
  endfunction

endpackage

// File: rtl/pp_pipeline_accel_blk_geom_if.sv
// ap_ctrl_chain handshake plus geometry request/result bundle.
interface pp_pipeline_accel_blk_geom_if
  import pp_pipeline_accel_blk_geom_pkg::*;
#(
  parameter int COLS_W = 16,
  parameter int NPPC_W = calc_nppc_w(8),
  parameter int WW     = calc_ww(8, 16)
) ();

  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic              ap_continue;
  logic              ap_idle;
  logic [COLS_W-1:0] cols;
  logic [NPPC_W-1:0] nppc;
  logic [COLS_W-1:0] num_blks;
  logic [NPPC_W-1:0] last_blk_pxls;
  logic [WW-1:0]     last_blk_width;
  logic              err;

  modport master (
    output ap_start, ap_continue, cols, nppc,
    input  ap_ready, ap_done, ap_idle, num_blks, last_blk_pxls, last_blk_width, err
  );

  modport slave (
    input  ap_start, ap_continue, cols, nppc,
    output ap_ready, ap_done, ap_idle, num_blks, last_blk_pxls, last_blk_width, err
  );

endinterface

// File: rtl/pp_pipeline_accel_seq_div.sv
// Restoring divider, one quotient bit per cycle MSB first; q_o/rem_o carry
// the final values during the cycle done_o is high.
module pp_pipeline_accel_seq_div #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DVD_W-1:0] q_o,
  output logic [DVS_W-1:0] rem_o
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam int REM_W = DVS_W + 1;

  logic [DVD_W-1:0] quo_q, quo_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [DVS_W-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic [REM_W:0]   shifted;
  logic             fits;

  // The quotient register doubles as the dividend shifter.
  always_comb begin
    shifted = {rem_q, quo_q[DVD_W-1]};
    fits    = (shifted >= {2'b00, dvs_q});
    quo_d   = {quo_q[DVD_W-2:0], fits};
    rem_d   = fits ? REM_W'(shifted - {2'b00, dvs_q}) : REM_W'(shifted);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start_i) begin
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
      cnt_q  <= CNT_W'(DVD_W);
      busy_q <= 1'b1;
    end else if (busy_q) begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_W'(1));
  assign q_o    = quo_d;
  assign rem_o  = rem_d[DVS_W-1:0];

endmodule

// File: rtl/pp_pipeline_accel_blk_geom.sv
// Block-geometry calculator: blocks per row, final block pixel count and
// bit width for a runtime cols/nppc pair, behind an ap_ctrl_chain handshake.
module pp_pipeline_accel_blk_geom
  import pp_pipeline_accel_blk_geom_pkg::*;
#(
  parameter int COLS_W   = 16,
  parameter int MAX_NPPC = 8,
  parameter int PXL_W    = 16
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  pp_pipeline_accel_blk_geom_if.slave  bus
);

  localparam int NPPC_W = calc_nppc_w(MAX_NPPC);
  localparam int WW     = calc_ww(MAX_NPPC, PXL_W);

  state_e            state_q, state_d;
  logic              accept;
  logic              form_result;
  logic              div_done;
  logic [COLS_W-1:0] div_q;
  logic [NPPC_W-1:0] div_rem;
  logic [NPPC_W-1:0] nppc_q;
  logic              legal_q;
  logic              cols_zero_q;
  logic [COLS_W-1:0] num_blks_q, num_blks_d;
  logic [NPPC_W-1:0] pxls_q, pxls_d;
  logic [WW-1:0]     width_q, width_d;
  logic              err_q, err_d;

  pp_pipeline_accel_seq_div #(
    .DVD_W (COLS_W),
    .DVS_W (NPPC_W)
  ) u_div (
    .clk        (ap_clk),
    .rst        (ap_rst),
    .start_i    (accept),
    .dividend_i (bus.cols),
    .divisor_i  (bus.nppc),
    .done_o     (div_done),
    .q_o        (div_q),
    .rem_o      (div_rem)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    form_result = 1'b0;
    unique case (state_q)
      IDLE: if (bus.ap_start) begin
        accept  = 1'b1;
        state_d = CALC;
      end
      CALC: if (div_done) begin
        form_result = 1'b1;
        state_d     = DONE;
      end
      DONE: if (bus.ap_continue) begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Illegal nppc still runs the divider for a fixed latency; its result is dropped.
  always_comb begin
    num_blks_d = '0;
    pxls_d     = '0;
    err_d      = 1'b0;
    if (!legal_q) begin
      err_d = 1'b1;
    end else if (!cols_zero_q) begin
      if (div_rem == '0) begin
        num_blks_d = div_q;
        pxls_d     = nppc_q;
      end else begin
        num_blks_d = div_q + COLS_W'(1);
        pxls_d     = div_rem;
      end
    end
    width_d = WW'(pxls_d) * WW'(PXL_W);
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      nppc_q      <= '0;
      legal_q     <= 1'b0;
      cols_zero_q <= 1'b0;
    end else if (accept) begin
      nppc_q      <= bus.nppc;
      legal_q     <= (bus.nppc != '0) && (bus.nppc <= NPPC_W'(MAX_NPPC));
      cols_zero_q <= (bus.cols == '0);
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      num_blks_q <= '0;
      pxls_q     <= '0;
      width_q    <= '0;
      err_q      <= 1'b0;
    end else if (form_result) begin
      num_blks_q <= num_blks_d;
      pxls_q     <= pxls_d;
      width_q    <= width_d;
      err_q      <= err_d;
    end
  end

  assign bus.ap_ready       = accept;
  assign bus.ap_done        = (state_q == DONE);
  assign bus.ap_idle        = (state_q == IDLE) && !bus.ap_start;
  assign bus.num_blks       = num_blks_q;
  assign bus.last_blk_pxls  = pxls_q;
  assign bus.last_blk_width = width_q;
  assign bus.err            = err_q;

endmodule
